// File: rtl/ifetch_pkg.sv
// ifetch_pkg: state encoding and default widths shared by ifetch and the microsequencer
package ifetch_pkg;

    localparam int DEF_OPCODE_WIDTH = 7;
    localparam int DEF_INSTR_WIDTH  = 16;
    localparam int DEF_PC_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction memory read bus between the fetch unit and memory
interface ifetch_if
    import ifetch_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) ();

    logic                   mem_req;
    logic [PC_WIDTH-1:0]    mem_addr;
    logic                   mem_ack;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/ifetch_pc.sv
// ifetch_pc: program counter with load, wrapping increment and async reset
module ifetch_pc
    import ifetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                inc,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] ONE = 1;

    logic [PC_WIDTH-1:0] pc_q, pc_d;

    // A load always beats an increment; the add wraps naturally at PC_WIDTH bits
    always_comb begin
        pc_d = load ? target : inc ? pc_q + ONE : pc_q;
    end

    // PC register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc_q <= RESET_VECTOR;
        else        pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch FSM and instruction register feeding the microsequencer
module ifetch
    import ifetch_pkg::*;
#(
    parameter int                  OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int                  INSTR_WIDTH  = DEF_INSTR_WIDTH,
    parameter int                  PC_WIDTH     = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                fetch,
    input  logic                                pc_load,
    input  logic [PC_WIDTH-1:0]                 pc_target,
    ifetch_if.master                            bus,
    output logic [OPCODE_WIDTH-1:0]             opcode,
    output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic [PC_WIDTH-1:0]                 pc,
    output logic                                busy,
    output logic                                instr_valid
);

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   valid_q, valid_d;
    logic                   take;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: fetch is only honoured in IDLE; a redirect without ack abandons the read
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (fetch) state_d = ST_FETCH;
            ST_FETCH:   if (bus.mem_ack) state_d = ST_IDLE;
                        else if (pc_load) state_d = ST_DISCARD;
            ST_DISCARD: if (bus.mem_ack) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: the request lives exactly as long as the transaction
    always_comb begin
        take    = state_q == ST_FETCH && bus.mem_ack && !pc_load;
        req_d   = state_d != ST_IDLE;
        addr_d  = (state_q == ST_IDLE && fetch) ? (pc_load ? pc_target : pc) : addr_q;
        ir_d    = take ? bus.mem_rdata : ir_q;
        valid_d = take;
    end

    // Registered bus outputs, instruction register and valid pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        busy         = state_q != ST_IDLE;
        opcode       = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
        operand      = ir_q[INSTR_WIDTH-OPCODE_WIDTH-1:0];
        instr_valid  = valid_q;
        bus.mem_req  = req_q;
        bus.mem_addr = addr_q;
    end

    ifetch_pc #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clock  (clock),
        .reset  (reset),
        .load   (pc_load),
        .inc    (take),
        .target (pc_target),
        .pc     (pc)
    );

endmodule
